// File: rtl/cart_save_streamer_pkg.sv
// Shared types for the cartridge save streamer: FSM states, transfer mode, sector geometry.
// Latency: n/a. Backpressure: n/a.
package cart_save_streamer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        XFER,
        NEXT,
        FINISH
    } state_t;

    typedef enum logic {
        LOAD,
        SAVE
    } mode_t;

    localparam int SECTOR_BYTES = 512;
    localparam int RTC_WORDS    = 4;

endpackage

// File: rtl/cart_save_streamer_handshake.sv
// Issues one SD sector request and holds it until the host acks it or the ack timer expires.
// Latency: request visible the clock after i_start. Backpressure: waits on i_ack.
module save_sd_handshake #(
    parameter logic [23:0] ACK_TIMEOUT = 24'hFFFFFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_write,
    input  logic i_ack,
    output logic o_rd,
    output logic o_wr,
    output logic o_ack_rise,
    output logic o_ack_fall,
    output logic o_timeout
);

    logic        r_pending;
    logic        r_write;
    logic        r_ack_d;
    logic [23:0] r_cnt;
    logic        w_ack_rise;
    logic        w_timeout;

    assign w_ack_rise = i_ack & ~r_ack_d;
    // An ack arriving on the last timer cycle still wins over the timeout.
    assign w_timeout  = r_pending & ~w_ack_rise & (r_cnt == ACK_TIMEOUT - 24'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_write   <= 1'b0;
            r_ack_d   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_ack_d <= i_ack;
            if (i_start) begin
                r_pending <= 1'b1;
                r_write   <= i_write;
                r_cnt     <= '0;
            end else if (r_pending) begin
                if (w_ack_rise || w_timeout) begin
                    r_pending <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 24'd1;
                end
            end
        end
    end

    assign o_rd       = r_pending & ~r_write;
    assign o_wr       = r_pending & r_write;
    assign o_ack_rise = r_pending & w_ack_rise;
    assign o_ack_fall = ~i_ack & r_ack_d;
    assign o_timeout  = w_timeout;

endmodule

// File: rtl/cart_save_streamer.sv
// Streams cart battery RAM to/from the SD save image one 512-byte sector at a time (SAVE_RTC_EN adds an RTC sector).
// Latency: bk_* follow the host buffer port combinationally; sd_buff_din is bk_q, one clock after the address.
// Backpressure: host paces via sd_ack; requests while busy are dropped.
module cart_save_streamer
    import cart_save_streamer_pkg::*;
#(
    parameter int          BUFF_AW     = 8,
    parameter int          LBA_W       = 32,
    parameter logic [23:0] ACK_TIMEOUT = 24'hFFFFFF
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               bk_load,
    input  logic               bk_save,
    input  logic               img_mounted,
    input  logic               img_readonly,
    input  logic [63:0]        img_size,
    input  logic               has_save,
    input  logic [7:0]         ram_mask_file,
    output logic [LBA_W-1:0]   sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    input  logic               sd_ack,
    input  logic [BUFF_AW-1:0] sd_buff_addr,
    input  logic [15:0]        sd_buff_dout,
    input  logic               sd_buff_wr,
    output logic [15:0]        sd_buff_din,
    output logic               bk_wr,
    output logic               bk_rtc_wr,
    output logic [16:0]        bk_addr,
    output logic [15:0]        bk_data,
    input  logic [15:0]        bk_q,
    output logic               busy,
    output logic               done,
    output logic               error
);

`ifdef SAVE_RTC_EN
    localparam bit RTC_EN = 1'b1;
`else
    localparam bit RTC_EN = 1'b0;
`endif

    state_t     r_state, w_state_nxt;
    mode_t      r_mode, w_mode_nxt;
    logic [8:0] r_sector, w_sector_nxt;
    logic       r_error, w_error_nxt;
    logic       r_ro_done, w_ro_done_nxt;
    logic       r_rtc, w_rtc_nxt;

    logic w_req_ok;
    logic w_last_ram;
    logic w_rtc_avail;
    logic w_rtc_word;
    logic w_xfer;
    logic w_hs_ack_rise;
    logic w_hs_ack_fall;
    logic w_hs_timeout;

    assign w_req_ok    = img_mounted & has_save & (|img_size);
    assign w_last_ram  = (r_sector == {1'b0, ram_mask_file});
    // The RTC sector only exists when the image is larger than the RAM payload.
    assign w_rtc_avail = RTC_EN &
        (img_size > (64'({1'b0, ram_mask_file}) + 64'd1) * 64'(SECTOR_BYTES));
    assign w_rtc_word  = r_rtc & (sd_buff_addr < BUFF_AW'(RTC_WORDS));
    assign w_xfer      = (r_state == XFER) & sd_ack;

    save_sd_handshake #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_handshake (
        .clk        (clk_sys),
        .rst_n      (reset_n),
        .i_start    (r_state == REQ),
        .i_write    (r_mode == SAVE),
        .i_ack      (sd_ack),
        .o_rd       (sd_rd),
        .o_wr       (sd_wr),
        .o_ack_rise (w_hs_ack_rise),
        .o_ack_fall (w_hs_ack_fall),
        .o_timeout  (w_hs_timeout)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_mode    <= LOAD;
            r_sector  <= '0;
            r_error   <= 1'b0;
            r_ro_done <= 1'b0;
            r_rtc     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_sector  <= w_sector_nxt;
            r_error   <= w_error_nxt;
            r_ro_done <= w_ro_done_nxt;
            r_rtc     <= w_rtc_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_sector_nxt  = r_sector;
        w_error_nxt   = r_error;
        w_ro_done_nxt = 1'b0;
        w_rtc_nxt     = r_rtc;
        case (r_state)
            IDLE: begin
                if (w_req_ok && bk_load) begin
                    w_state_nxt  = REQ;
                    w_mode_nxt   = LOAD;
                    w_sector_nxt = '0;
                    w_error_nxt  = 1'b0;
                    w_rtc_nxt    = 1'b0;
                end else if (w_req_ok && bk_save) begin
                    if (img_readonly) begin
                        w_error_nxt   = 1'b1;
                        w_ro_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = REQ;
                        w_mode_nxt   = SAVE;
                        w_sector_nxt = '0;
                        w_error_nxt  = 1'b0;
                        w_rtc_nxt    = 1'b0;
                    end
                end
            end
            REQ:      w_state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (w_hs_timeout) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = FINISH;
                end else if (w_hs_ack_rise) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (w_hs_ack_fall) w_state_nxt = NEXT;
            end
            NEXT: begin
                if (r_rtc || (w_last_ram && !w_rtc_avail)) begin
                    w_state_nxt = FINISH;
                end else begin
                    w_sector_nxt = r_sector + 9'd1;
                    w_state_nxt  = REQ;
                    if (w_last_ram) w_rtc_nxt = 1'b1;
                end
            end
            FINISH:   w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bk_addr = '0;
        if (r_state == XFER) begin
            if (r_rtc) bk_addr = 17'(sd_buff_addr[3:0]);
            else       bk_addr = 17'({r_sector[7:0], sd_buff_addr});
        end
    end

    assign sd_lba      = LBA_W'(r_sector);
    assign bk_wr       = w_xfer & (r_mode == LOAD) & sd_buff_wr & ~r_rtc;
    assign bk_rtc_wr   = RTC_EN & w_xfer & (r_mode == LOAD) & sd_buff_wr & w_rtc_word;
    assign bk_data     = (w_xfer && r_mode == LOAD) ? sd_buff_dout : 16'd0;
    assign sd_buff_din = (r_state == XFER && r_mode == SAVE) ? bk_q : 16'd0;
    assign busy        = (r_state == REQ) || (r_state == WAIT_ACK) ||
                         (r_state == XFER) || (r_state == NEXT);
    assign done        = (r_state == FINISH) | r_ro_done;
    assign error       = r_error;

endmodule

// File: tb/tb_cart_save_streamer.sv
// Bench for cart_save_streamer: host SD model, cart RAM model, write scoreboard, request table.
module tb_cart_save_streamer;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        bk_load, bk_save, img_mounted, img_readonly, has_save;
    logic [63:0] img_size;
    logic [7:0]  ram_mask_file;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout, sd_buff_din;
    logic        sd_buff_wr;
    logic        bk_wr, bk_rtc_wr;
    logic [16:0] bk_addr;
    logic [15:0] bk_data, bk_q;
    logic        busy, done, error;

    cart_save_streamer #(
        .BUFF_AW     (8),
        .LBA_W       (32),
        .ACK_TIMEOUT (24'd100)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .bk_load       (bk_load),
        .bk_save       (bk_save),
        .img_mounted   (img_mounted),
        .img_readonly  (img_readonly),
        .img_size      (img_size),
        .has_save      (has_save),
        .ram_mask_file (ram_mask_file),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_addr  (sd_buff_addr),
        .sd_buff_dout  (sd_buff_dout),
        .sd_buff_wr    (sd_buff_wr),
        .sd_buff_din   (sd_buff_din),
        .bk_wr         (bk_wr),
        .bk_rtc_wr     (bk_rtc_wr),
        .bk_addr       (bk_addr),
        .bk_data       (bk_data),
        .bk_q          (bk_q),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input logic [16:0] a);
        return a[15:0] * 16'd3 ^ 16'h3C5A;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({busy, done, error, sd_rd, sd_wr, bk_wr, bk_rtc_wr, bk_addr, bk_data, sd_buff_din});
    endfunction

    // Cart RAM model: read-only, 1-clock read latency.
    logic [15:0] ram [0:4095];
    initial forever begin
        @(posedge clk_sys);
        bk_q <= ram[bk_addr[11:0]];
    end

    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t sb[$];

    int n_bkwr = 0;
    int n_done = 0;
    int n_rtc  = 0;

    initial begin
        wr_t e;
        forever begin
            @(negedge clk_sys);
            if (bk_wr) begin
                n_bkwr++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bk_wr_unexpected actual addr=%0h required none", bk_addr);
                end else begin
                    e = sb.pop_front();
                    chk("bk_addr", 64'(bk_addr), 64'(e.addr));
                    chk("bk_data", 64'(bk_data), 64'(e.data));
                end
            end
            if (done) n_done++;
            if (bk_rtc_wr) n_rtc++;
        end
    end

    bit host_en = 1'b1;
    int exp_lba = 0;
    int n_sect = 0;
    bit last_rd = 1'b0;
    int cur_lba = -1;
    int cur_word = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic do_sector();
        logic        is_rd;
        logic [31:0] lba;
        logic [16:0] a;
        wr_t         e;
        is_rd = sd_rd;
        lba   = sd_lba;
        chk("sd_lba", 64'(lba), 64'(exp_lba));
        exp_lba++;
        n_sect++;
        last_rd = is_rd;
        cur_lba = int'(lba);
        step(2);
        sd_ack = 1'b1;
        step(2);
        for (int w = 0; w < 256; w++) begin
            if (!reset_n) break;
            cur_word = w;
            a = {1'b0, lba[7:0], w[7:0]};
            sd_buff_addr = w[7:0];
            if (is_rd) begin
                sd_buff_dout = pat(a);
                sd_buff_wr = 1'b1;
                e.addr = a;
                e.data = pat(a);
                sb.push_back(e);
                step(1);
                sd_buff_wr = 1'b0;
                step(1);
            end else begin
                step(1);
                if (!reset_n) break;
                chk("sd_buff_din", 64'(sd_buff_din), 64'(ram[a[11:0]]));
                step(1);
            end
        end
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        step(2);
    endtask

    initial forever begin
        @(posedge clk_sys);
        #1;
        if (host_en && reset_n && (sd_rd || sd_wr)) do_sector();
    end

    task automatic pulse_req(input logic l, input logic s);
        bk_load = l;
        bk_save = s;
        step(1);
        bk_load = 1'b0;
        bk_save = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lim);
        int n0;
        n0 = n_done;
        for (int k = 0; k < lim; k++) begin
            if (n_done != n0) break;
            step(1);
        end
        chk({name, "_done_seen"}, 64'(n_done != n0), 64'd1);
    endtask

    task automatic set_img(input logic [7:0] mask);
        img_mounted   = 1'b1;
        img_readonly  = 1'b0;
        has_save      = 1'b1;
        ram_mask_file = mask;
        img_size      = (64'(mask) + 64'd1) * 64'd512;
    endtask

    typedef struct {
        bit          ld, sv, mnt, ro, has;
        logic [63:0] size;
        bit          exp_busy, exp_done, exp_err, exp_rd;
    } vec_t;
    vec_t vecs[10];

    initial begin
        int ns0, nb0, nd0, cyc;
        bit hit;

        #10_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns0, nb0, nd0, cyc;
        bit hit;

        vecs[0] = '{T, F, T, F, T, 64'd512, T, F, F, T};
        vecs[1] = '{F, T, T, F, T, 64'd512, T, F, F, F};
        vecs[2] = '{F, T, T, T, T, 64'd512, F, T, T, F};
        vecs[3] = '{T, F, T, T, T, 64'd512, T, F, F, T};
        vecs[4] = '{T, F, F, F, T, 64'd512, F, F, F, F};
        vecs[5] = '{F, T, T, T, T, 64'd512, F, T, T, F};
        vecs[6] = '{T, F, T, F, F, 64'd512, F, F, T, F};
        vecs[7] = '{T, F, T, F, T, 64'd0,   F, F, T, F};
        vecs[8] = '{T, T, T, F, T, 64'd512, T, F, F, T};
        vecs[9] = '{F, F, T, F, T, 64'd512, F, F, F, F};

        for (int i = 0; i < 4096; i++) ram[i] = ~pat(17'(i));
        reset_n = 1'b0;
        bk_load = 1'b0;
        bk_save = 1'b0;
        sd_ack = 1'b0;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        sd_buff_wr = 1'b0;
        set_img(8'd0);
        step(3);
        chk("reset_outputs", outs(), 64'd0);
        chk("reset_lba", 64'(sd_lba), 64'd0);
        reset_n = 1'b1;
        step(2);
        chk("idle_outputs", outs(), 64'd0);

        // Request acceptance table (single-sector image).
        for (int i = 0; i < 10; i++) begin
            img_mounted  = vecs[i].mnt;
            img_readonly = vecs[i].ro;
            has_save     = vecs[i].has;
            img_size     = vecs[i].size;
            exp_lba = 0;
            ns0 = n_sect;
            pulse_req(vecs[i].ld, vecs[i].sv);
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
            chk($sformatf("vec%0d_error", i), 64'(error), 64'(vecs[i].exp_err));
            if (vecs[i].exp_busy) begin
                wait_done($sformatf("vec%0d", i), 2000);
                chk($sformatf("vec%0d_mode_rd", i), 64'(last_rd), 64'(vecs[i].exp_rd));
                chk($sformatf("vec%0d_sectors", i), 64'(n_sect - ns0), 64'd1);
                chk($sformatf("vec%0d_end_error", i), 64'(error), 64'd0);
                chk($sformatf("vec%0d_end_busy", i), 64'(busy), 64'd0);
            end
            step(2);
        end

        // Host never acks: timeout.
        set_img(8'd0);
        host_en = 1'b0;
        pulse_req(1'b1, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (sd_rd) begin hit = 1'b1; break; end
            step(1);
        end
        chk("timeout_sd_rd_seen", 64'(hit), 64'd1);
        nd0 = n_done;
        cyc = 0;
        while (n_done == nd0 && cyc < 300) begin
            step(1);
            cyc++;
        end
        chk("timeout_window", 64'(cyc >= 95 && cyc <= 110), 64'd1);
        chk("timeout_error", 64'(error), 64'd1);
        chk("timeout_busy", 64'(busy), 64'd0);
        chk("timeout_sd_rd", 64'(sd_rd), 64'd0);
        host_en = 1'b1;
        step(3);

        // Full load of 16 sectors.
        set_img(8'h0F);
        exp_lba = 0;
        nb0 = n_bkwr;
        nd0 = n_done;
        pulse_req(1'b1, 1'b0);
        chk("load16_busy", 64'(busy), 64'd1);
        chk("load16_error_cleared", 64'(error), 64'd0);
        wait_done("load16", 12000);
        step(3);
        chk("load16_sectors", 64'(exp_lba), 64'd16);
        chk("load16_bk_wr_count", 64'(n_bkwr - nb0), 64'd4096);
        chk("load16_sb_empty", 64'(sb.size()), 64'd0);
        chk("load16_done_pulses", 64'(n_done - nd0), 64'd1);
        chk("load16_error", 64'(error), 64'd0);

        // Save of 4 sectors.
        set_img(8'h03);
        exp_lba = 0;
        nb0 = n_bkwr;
        nd0 = n_done;
        pulse_req(1'b0, 1'b1);
        wait_done("save4", 5000);
        step(3);
        chk("save4_sectors", 64'(exp_lba), 64'd4);
        chk("save4_mode_rd", 64'(last_rd), 64'd0);
        chk("save4_error", 64'(error), 64'd0);
        chk("save4_done_pulses", 64'(n_done - nd0), 64'd1);
        chk("save4_no_bk_wr", 64'(n_bkwr - nb0), 64'd0);

        // Save request while a load is in flight is ignored.
        set_img(8'd0);
        exp_lba = 0;
        ns0 = n_sect;
        pulse_req(1'b1, 1'b0);
        step(10);
        pulse_req(1'b0, 1'b1);
        chk("busy_ignore_busy", 64'(busy), 64'd1);
        wait_done("busy_ignore", 2000);
        step(20);
        chk("busy_ignore_sectors", 64'(n_sect - ns0), 64'd1);
        chk("busy_ignore_mode_rd", 64'(last_rd), 64'd1);

        // Host data strobe while idle must not reach cart RAM.
        sd_buff_addr = 8'h12;
        sd_buff_dout = 16'hBEEF;
        sd_buff_wr = 1'b1;
        #1;
        chk("idle_bk_wr", 64'(bk_wr), 64'd0);
        chk("idle_bk_data", 64'(bk_data), 64'd0);
        step(1);
        sd_buff_wr = 1'b0;
        step(1);

        // Reset during sector 2 of a load.
        set_img(8'h0F);
        exp_lba = 0;
        cur_lba = -1;
        cur_word = 0;
        pulse_req(1'b1, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (cur_lba == 2 && cur_word >= 20) begin hit = 1'b1; break; end
            step(1);
        end
        chk("reset_mid_reached", 64'(hit), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_outputs", outs(), 64'd0);
        chk("reset_mid_lba", 64'(sd_lba), 64'd0);
        nb0 = n_bkwr;
        step(8);
        chk("reset_mid_no_bk_wr", 64'(n_bkwr - nb0), 64'd0);
        sb.delete();
        reset_n = 1'b1;
        step(4);
        set_img(8'h01);
        exp_lba = 0;
        ns0 = n_sect;
        pulse_req(1'b1, 1'b0);
        wait_done("after_reset", 3000);
        step(3);
        chk("after_reset_sectors", 64'(n_sect - ns0), 64'd2);
        chk("after_reset_error", 64'(error), 64'd0);
        chk("after_reset_sb_empty", 64'(sb.size()), 64'd0);
        chk("rtc_wr_count", 64'(n_rtc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
